// File: rtl/casilla_cursor.sv
// casilla_cursor: board-cell cursor that skips occupied cells and offers a chosen free cell over valid/ready
module casilla_cursor #(
  parameter int N_CELLS = 9,
  parameter int IDX_W   = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic               next,
  input  logic               select,
  input  logic [N_CELLS-1:0] occupied,
  input  logic               cell_ready,
  output logic [IDX_W-1:0]   cell_idx,
  output logic               cell_valid,
  output logic               busy,
  output logic               no_free
);
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SEEK   = 2'd1;
  localparam logic [1:0] COMMIT = 2'd2;
  localparam logic [1:0] FULL   = 2'd3;
  localparam int OW = 1 << IDX_W;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(N_CELLS - 1);
  localparam logic [IDX_W:0] STEPS_ALL = (IDX_W + 1)'(N_CELLS);
  logic [1:0]       state;
  logic [IDX_W-1:0] cursor, cursor_inc;
  logic [IDX_W:0]   steps;
  logic             next_q, select_q, nr, sr, cur_occ;
  logic [OW-1:0]    occ_ext;
  // widen so the cursor can index the vector for any legal IDX_W
  assign occ_ext    = OW'(occupied);
  assign cur_occ    = occ_ext[cursor];
  assign cursor_inc = cursor == LAST ? '0 : cursor + IDX_W'(1);
  assign nr         = next & ~next_q & enable;
  assign sr         = select & ~select_q & enable;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cursor   <= '0;
      steps    <= '0;
      next_q   <= 1'b0;
      select_q <= 1'b0;
    end else begin
      next_q   <= next;
      select_q <= select;
      case (state)
        IDLE:
          if (sr && !cur_occ) state <= COMMIT;
          else if (nr || cur_occ) begin
            cursor <= cursor_inc;
            steps  <= (IDX_W + 1)'(1);
            state  <= SEEK;
          end
        SEEK:
          if (!cur_occ) state <= IDLE;
          else if (steps == STEPS_ALL) state <= FULL;
          else begin
            cursor <= cursor_inc;
            steps  <= steps + (IDX_W + 1)'(1);
          end
        COMMIT:
          if (cell_ready) state <= IDLE;
        default:
          if (!(&occupied)) state <= IDLE;
      endcase
    end
  end
  assign cell_idx   = cursor;
  assign cell_valid = state == COMMIT;
  assign busy       = state == SEEK;
  assign no_free    = state == FULL;
endmodule

// File: tb/tb_casilla_cursor.sv
// tb_casilla_cursor: randomized scoreboard bench for casilla_cursor against a search-based cursor model
module tb_casilla_cursor;
  localparam int N = 9;
  localparam int IW = 4;
  logic clk = 0, rst_n = 0, enable = 1, next = 0, select = 0, cell_ready = 0;
  logic [N-1:0] occupied = '0;
  logic [IW-1:0] cell_idx;
  logic cell_valid, busy, no_free;
  int checks = 0, failures = 0, cyc = 0;
  int m_cur = 0;
  bit m_full = 0;
  typedef struct {int idx; int len; int start; int full;} seek_t;
  typedef struct {int idx; int start; int fin;} off_t;
  seek_t sq[$];
  off_t oq[$];
  seek_t cs;
  off_t co;
  bit s_act = 0, o_act = 0, pb = 0, pv = 0;
  int blen = 0;

  casilla_cursor #(.N_CELLS(N), .IDX_W(IW)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .next(next), .select(select),
    .occupied(occupied), .cell_ready(cell_ready), .cell_idx(cell_idx),
    .cell_valid(cell_valid), .busy(busy), .no_free(no_free)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at cycle %0d", name, act, exp, cyc);
    end
  endtask

  function automatic int inc(input int c);
    return c == N - 1 ? 0 : c + 1;
  endfunction

  // model: first free cell after the cursor, wrapping; every visited cell costs one busy cycle
  task automatic do_seek(input int start);
    int c = m_cur;
    for (int k = 1; k <= N; k++) begin
      c = inc(c);
      if (!occupied[c]) begin
        sq.push_back('{c, k, start, 0});
        m_cur = c;
        return;
      end
    end
    sq.push_back('{m_cur, N, start, 1});
    m_full = 1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_quiet();
    int n = 0;
    while (busy || cell_valid || sq.size() != 0 || oq.size() != 0 || s_act || o_act) begin
      tick();
      if (++n > 60) begin
        chk("quiet_timeout", n, 0);
        sq.delete();
        oq.delete();
        break;
      end
    end
    chk("cursor", cell_idx, m_cur);
    chk("no_free", no_free, m_full);
  endtask

  task automatic press_next();
    if (enable && !m_full) do_seek(cyc + 1);
    next = 1;
    tick();
    next = 0;
    tick();
    wait_quiet();
  endtask

  task automatic set_occ(input logic [N-1:0] v);
    int c = cyc;
    occupied = v;
    if (m_full) begin
      if (!(&v)) begin
        m_full = 0;
        if (v[m_cur]) do_seek(c + 2);
      end
    end else if (v[m_cur]) do_seek(c + 1);
    tick();
    wait_quiet();
  endtask

  task automatic op_select(input int hold, input int rd, input bit noise);
    int c = cyc;
    if (enable && !m_full) oq.push_back('{m_cur, c + 1, (c + 2 > c + rd + 1) ? c + 2 : c + rd + 1});
    select = 1;
    cell_ready = rd == 0;
    for (int j = 1; j <= 10; j++) begin
      tick();
      select = j < hold;
      cell_ready = j >= rd;
      next = noise && (j % 2 == 1) && j < rd;
    end
    select = 0;
    next = 0;
    cell_ready = 0;
    tick();
    wait_quiet();
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      pb = 0; pv = 0; s_act = 0; o_act = 0;
    end else begin
      if (busy && !pb) begin
        chk("seek_expected", int'(sq.size() != 0), 1);
        if (sq.size() != 0) begin
          cs = sq.pop_front();
          s_act = 1;
          blen = 0;
          chk("seek_start", cyc, cs.start);
        end
      end
      if (busy) blen++;
      if (!busy && pb && s_act) begin
        chk("seek_len", blen, cs.len);
        chk("seek_idx", cell_idx, cs.idx);
        chk("seek_full", no_free, cs.full);
        s_act = 0;
      end
      if (cell_valid && !pv) begin
        chk("offer_expected", int'(oq.size() != 0), 1);
        if (oq.size() != 0) begin
          co = oq.pop_front();
          o_act = 1;
          chk("offer_start", cyc, co.start);
        end
      end
      if (cell_valid && o_act) chk("offer_idx", cell_idx, co.idx);
      if (!cell_valid && pv && o_act) begin
        chk("offer_end", cyc, co.fin);
        o_act = 0;
      end
      pb = busy;
      pv = cell_valid;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_idx", cell_idx, 0);
    chk("rst_valid", cell_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_no_free", no_free, 0);
    rst_n = 1;
    tick();
    repeat (3) press_next();
    while (m_cur != 8) press_next();
    press_next();
    chk("wrap", cell_idx, 0);
    press_next();
    press_next();
    set_occ(9'b000111000);
    press_next();
    chk("skip_to_6", cell_idx, 6);
    set_occ('0);
    while (m_cur != 4) press_next();
    op_select(5, 4, 1);
    set_occ('1);
    press_next();
    set_occ(9'b101111111);
    chk("settle_7", cell_idx, 7);
    enable = 0;
    press_next();
    op_select(1, 1, 0);
    enable = 1;
    for (int i = 0; i < 150; i++) begin
      int op = $urandom_range(0, 9);
      enable = $urandom_range(0, 4) != 0;
      if (op <= 3) press_next();
      else if (op <= 6) op_select($urandom_range(1, 5), $urandom_range(0, 4), 1'($urandom_range(0, 1)));
      else if (op == 7) set_occ($urandom_range(0, 7) == 0 ? '1 : N'($urandom & $urandom));
      else if (op == 8) set_occ(occupied | N'(1 << m_cur));
      else set_occ('0);
    end
    enable = 1;
    set_occ('0);
    press_next();
    oq.push_back('{m_cur, cyc + 1, 0});
    select = 1;
    tick();
    tick();
    rst_n = 0;
    #1;
    chk("mid_rst_valid", cell_valid, 0);
    chk("mid_rst_idx", cell_idx, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_no_free", no_free, 0);
    select = 0;
    oq.delete();
    m_cur = 0;
    m_full = 0;
    tick();
    rst_n = 1;
    tick();
    press_next();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
